// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access width codes, FSM states and width helper for the load/store unit.
package load_store_unit_pkg;
  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;
  typedef enum logic [2:0] {S_IDLE, S_REQ_LO, S_RSP_LO, S_REQ_HI, S_RSP_HI, S_ERR} state_e;
  function automatic logic [2:0] access_bytes(input logic [2:0] w);
    return w[1:0] == 2'b00 ? 3'd1 : w[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/load_store_unit_align.sv
// load_store_unit_align: byte-lane steering for stores and extraction/extension for loads over a two-word window.
module load_store_unit_align import load_store_unit_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]           off_i,
  input  logic [2:0]              width_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH-1:0]   rlo_i,
  input  logic [DATA_WIDTH-1:0]   rhi_i,
  output logic [2*NB-1:0]         wstrb_o,
  output logic [2*DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    crosses_o,
  output logic                    misaligned_o,
  output logic                    illegal_o
);
  logic [2:0] nbytes;
  logic [3:0] bmask;
  logic [DATA_WIDTH-1:0] raw;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] w;
  assign nbytes = access_bytes(width_i);
  assign bmask = nbytes == 3'd1 ? 4'h1 : nbytes == 3'd2 ? 4'h3 : 4'hF;
  // Two-word windows: the upper half feeds the second bus transaction of a split.
  assign wstrb_o = (2*NB)'(bmask) << off_i;
  assign wdata_o = (2*DATA_WIDTH)'(wdata_i) << {off_i, 3'b000};
  assign raw = DATA_WIDTH'({rhi_i, rlo_i} >> {off_i, 3'b000});
  assign b = raw[7:0];
  assign h = raw[15:0];
  assign w = raw[31:0];
  assign rdata_o = width_i == W_B  ? DATA_WIDTH'($signed(b)) :
                   width_i == W_H  ? DATA_WIDTH'($signed(h)) :
                   width_i == W_W  ? DATA_WIDTH'($signed(w)) :
                   width_i == W_BU ? DATA_WIDTH'(b) :
                   width_i == W_HU ? DATA_WIDTH'(h) : '0;
  assign crosses_o = ({1'b0, off_i} + (OW+1)'(nbytes)) > (OW+1)'(NB);
  assign misaligned_o = (off_i[1:0] & (nbytes[1:0] - 2'd1)) != 2'd0;
  assign illegal_o = (&width_i[1:0]) || (width_i[2] && width_i[1]);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: request/response front-end to a word-wide data bus, splitting word-crossing accesses.
module load_store_unit import load_store_unit_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ALLOW_MISALIGNED = 1,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_width_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  busy_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [NB-1:0]         mem_wstrb_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  state_e state_q, state_d;
  logic we_q, split_q, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [2:0] width_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [OW-1:0] off_q;
  logic [DATA_WIDTH-1:0] wdata_q, lo_q, rsp_rdata_q, rsp_rdata_d;
  logic accept, hi, err_s, crosses, misaligned, illegal;
  logic [2*NB-1:0] strb2;
  logic [2*DATA_WIDTH-1:0] wdata2;
  logic [DATA_WIDTH-1:0] rdata_ext, rlo, rhi;
  assign req_ready_o = state_q == S_IDLE && !rsp_valid_q;
  assign accept = req_valid_i && req_ready_o;
  assign busy_o = (!req_ready_o && !rsp_valid_q) || accept;
  assign rlo = state_q == S_RSP_HI ? lo_q : mem_rdata_i;
  assign rhi = state_q == S_RSP_HI ? mem_rdata_i : '0;
  // In IDLE the aligner looks at the incoming request to classify it; afterwards at the captured one.
  load_store_unit_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off_i       (state_q == S_IDLE ? req_addr_i[OW-1:0] : off_q),
    .width_i     (state_q == S_IDLE ? req_width_i : width_q),
    .wdata_i     (wdata_q),
    .rlo_i       (rlo),
    .rhi_i       (rhi),
    .wstrb_o     (strb2),
    .wdata_o     (wdata2),
    .rdata_o     (rdata_ext),
    .crosses_o   (crosses),
    .misaligned_o(misaligned),
    .illegal_o   (illegal)
  );
  assign err_s = illegal || (misaligned && ALLOW_MISALIGNED == 0);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = accept ? (err_s ? S_ERR : S_REQ_LO) : S_IDLE;
      S_REQ_LO: state_d = mem_gnt_i ? S_RSP_LO : S_REQ_LO;
      S_RSP_LO: state_d = mem_rvalid_i ? (split_q ? S_REQ_HI : S_IDLE) : S_RSP_LO;
      S_REQ_HI: state_d = mem_gnt_i ? S_RSP_HI : S_REQ_HI;
      S_RSP_HI: state_d = mem_rvalid_i ? S_IDLE : S_RSP_HI;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_q == S_RSP_LO && mem_rvalid_i && !split_q) ||
                  (state_q == S_RSP_HI && mem_rvalid_i) || state_q == S_ERR;
    rsp_err_d = state_q == S_ERR;
    rsp_rdata_d = (rsp_valid_d && !we_q && !rsp_err_d) ? rdata_ext : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      width_q     <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        we_q    <= req_we_i;
        width_q <= req_width_i;
        addr_q  <= {req_addr_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        off_q   <= req_addr_i[OW-1:0];
        wdata_q <= req_wdata_i;
        split_q <= crosses && !err_s;
      end
      if (state_q == S_RSP_LO && mem_rvalid_i) lo_q <= mem_rdata_i;
    end
  end
  assign hi = state_q == S_REQ_HI;
  assign mem_req_o = state_q == S_REQ_LO || hi;
  assign mem_we_o = mem_req_o && we_q;
  assign mem_addr_o = !mem_req_o ? '0 : hi ? addr_q + ADDR_WIDTH'(NB) : addr_q;
  assign mem_wstrb_o = !mem_we_o ? '0 : hi ? strb2[2*NB-1:NB] : strb2[NB-1:0];
  assign mem_wdata_o = !mem_we_o ? '0 : hi ? wdata2[2*DATA_WIDTH-1:DATA_WIDTH] : wdata2[DATA_WIDTH-1:0];
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against two instances (misaligned split allowed / rejected).
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_valid0 = 0, req_we = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [2:0] req_width = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic req_ready, busy, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic req_ready0, busy0, rsp_valid0, rsp_err0, mem_req0, mem_we0;
  logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0;
  logic [3:0] mem_wstrb0;
  load_store_unit #(.ALLOW_MISALIGNED(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_width_i(req_width), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .busy_o(busy), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );
  load_store_unit #(.ALLOW_MISALIGNED(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .req_we_i(req_we), .req_width_i(req_width), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .busy_o(busy0), .rsp_valid_o(rsp_valid0), .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0),
    .mem_req_o(mem_req0), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we0), .mem_addr_o(mem_addr0),
    .mem_wstrb_o(mem_wstrb0), .mem_wdata_o(mem_wdata0), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );
  int n_chk = 0, n_fail = 0;
  int lat, nreq;
  logic t_busy, t_ready, t_we, er;
  logic [31:0] a0, a1, d0, d1, rd;
  logic [3:0] s0, s1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One access on the main instance with an always-granting bus answering one cycle after each grant.
  task automatic run(input logic we, input logic [2:0] w, input logic [31:0] a, wd, r0, r1);
    logic pend;
    @(negedge clk);
    req_valid = 1; req_we = we; req_width = w; req_addr = a; req_wdata = wd; mem_gnt = 1;
    #1 t_busy = busy; t_ready = req_ready;
    @(negedge clk);
    req_valid = 0;
    lat = -1; nreq = 0; pend = 0; t_we = 0; er = 0; rd = 'x;
    a0 = 'x; a1 = 'x; s0 = 'x; s1 = 'x; d0 = 'x; d1 = 'x;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      mem_rvalid = pend;
      mem_rdata = pend ? (nreq == 1 ? r0 : r1) : 32'h0;
      pend = 0;
      #1;
      if (mem_req) begin
        if (nreq == 0) begin a0 = mem_addr; s0 = mem_wstrb; d0 = mem_wdata; t_we = mem_we; end
        else begin a1 = mem_addr; s1 = mem_wstrb; d1 = mem_wdata; end
        nreq++;
        pend = 1;
      end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; end
      @(negedge clk);
    end
    mem_rvalid = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1;
    run(0, W_W, 32'h100, 0, 32'hDEADBEEF, 0);
    check("lw_busy_accept", t_busy, 1);
    check("lw_ready_accept", t_ready, 1);
    check("lw_addr", a0, 32'h100);
    check("lw_wstrb", s0, 0);
    check("lw_we", t_we, 0);
    check("lw_nreq", nreq, 1);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_lat", lat, 3);
    run(0, W_B, 32'h103, 0, 32'h80FFFFFF, 0);
    check("lb_rdata", rd, 32'hFFFFFF80);
    run(0, W_BU, 32'h103, 0, 32'h80FFFFFF, 0);
    check("lbu_rdata", rd, 32'h00000080);
    run(0, W_H, 32'h102, 0, 32'h80001234, 0);
    check("lh_rdata", rd, 32'hFFFF8000);
    run(0, W_HU, 32'h102, 0, 32'h80001234, 0);
    check("lhu_rdata", rd, 32'h00008000);
    run(0, W_H, 32'h101, 0, 32'h00ABCD00, 0);
    check("lh_mis_nreq", nreq, 1);
    check("lh_mis_rdata", rd, 32'hFFFFABCD);
    check("lh_mis_lat", lat, 3);
    run(1, W_H, 32'h102, 32'h1234, 32'hFFFFFFFF, 0);
    check("sh_we", t_we, 1);
    check("sh_wstrb", s0, 4'b1100);
    check("sh_wdata", d0, 32'h12340000);
    check("sh_rdata", rd, 0);
    check("sh_lat", lat, 3);
    run(0, W_W, 32'h101, 0, 32'h44332211, 32'h88776655);
    check("lw_split_nreq", nreq, 2);
    check("lw_split_addr0", a0, 32'h100);
    check("lw_split_addr1", a1, 32'h104);
    check("lw_split_rdata", rd, 32'h55443322);
    check("lw_split_lat", lat, 5);
    run(1, W_W, 32'h102, 32'hAABBCCDD, 0, 0);
    check("sw_split_strb0", s0, 4'b1100);
    check("sw_split_data0", d0, 32'hCCDD0000);
    check("sw_split_strb1", s1, 4'b0011);
    check("sw_split_data1", d1, 32'h0000AABB);
    check("sw_split_lat", lat, 5);
    run(0, 3'b011, 32'h100, 0, 0, 0);
    check("illegal_nreq", nreq, 0);
    check("illegal_err", er, 1);
    check("illegal_lat", lat, 2);
    // Word-crossing load on the instance that rejects misalignment.
    @(negedge clk);
    req_valid0 = 1; req_we = 0; req_width = W_W; req_addr = 32'h101; mem_gnt = 1;
    #1 check("mis0_busy_accept", busy0, 1);
    @(negedge clk);
    req_valid0 = 0;
    #1 check("mis0_req_t1", mem_req0, 0);
    check("mis0_valid_t1", rsp_valid0, 0);
    @(negedge clk);
    #1 check("mis0_valid_t2", rsp_valid0, 1);
    check("mis0_err", rsp_err0, 1);
    check("mis0_rdata", rsp_rdata0, 0);
    check("mis0_busy_rsp", busy0, 0);
    // Reset while waiting for the read response, then a stale response arrives.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_width = W_W; req_addr = 32'h300; mem_gnt = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1 check("rstmid_mem_req", mem_req, 0);
    check("rstmid_ready", req_ready, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 0;
    #1 check("rstmid_no_rsp1", rsp_valid, 0);
    @(negedge clk);
    #1 check("rstmid_no_rsp2", rsp_valid, 0);
    check("rstmid_ready2", req_ready, 1);
    // Store with the bus withholding grant for three cycles.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_width = W_W; req_addr = 32'h200; req_wdata = 32'h11223344; mem_gnt = 0;
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, 32'h200);
      check("stall_wstrb", mem_wstrb, 4'hF);
      check("stall_wdata", mem_wdata, 32'h11223344);
      check("stall_busy", busy, 1);
      if (i == 2) mem_gnt = 1;
      @(negedge clk);
    end
    mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    #1 check("stall_busy_rsplo", busy, 1);
    check("stall_req_off", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 0;
    #1 check("stall_rsp_valid", rsp_valid, 1);
    check("stall_busy_rsp", busy, 0);
    check("stall_rdata", rsp_rdata, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
